// File: rtl/pattern_gen_pkg.sv
// Shared types and constants for the parametrised pattern generator.
package pattern_gen_pkg;

    typedef enum logic [2:0] {
        PG_CONST   = 3'd0,
        PG_RAMP_X  = 3'd1,
        PG_RAMP_Y  = 3'd2,
        PG_RAMP_XY = 3'd3,
        PG_CHECKER = 3'd4,
        PG_PRBS    = 3'd5
    } pg_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_LINE,
        ST_ACTIVE
    } pg_state_e;

    // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: taps at bits 0,2,3,5
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Width of a counter over 0..n-1, never narrower than one bit
    function automatic int pg_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pattern_gen_param_if.sv
// Sync/config inputs and pixel outputs of the pattern generator.
interface pattern_gen_param_if
    import pattern_gen_pkg::*;
#(
    parameter int DATA_W      = 12,
    parameter int DELTA_W     = 2,
    parameter int LINE_LEN    = 640,
    parameter int FRAME_LINES = 480
) ();
    localparam int PX_W = pg_w(LINE_LEN);
    localparam int LY_W = pg_w(FRAME_LINES);

    logic                f_sync;
    logic                sync;
    logic [DATA_W-1:0]   constVal;
    logic [DELTA_W-1:0]  X;
    logic [DELTA_W-1:0]  Y;
    logic [2:0]          Mode;

    logic [DATA_W-1:0]   cnt;
    logic                cnt_vld;
    logic [PX_W-1:0]     pix_x;
    logic [LY_W-1:0]     line_y;
    logic                frame_done;

    modport master (
        output f_sync, sync, constVal, X, Y, Mode,
        input  cnt, cnt_vld, pix_x, line_y, frame_done
    );

    modport slave (
        input  f_sync, sync, constVal, X, Y, Mode,
        output cnt, cnt_vld, pix_x, line_y, frame_done
    );
endinterface

// File: rtl/pattern_gen_lfsr.sv
// 16-bit Fibonacci LFSR used for the PRBS pattern; load wins over enable.
module pattern_gen_lfsr
    import pattern_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] value
);
    logic fb;

    // Feedback is the parity of the tapped bits
    always_comb fb = ^(value & LFSR_TAPS);

    // Shift right, new bit enters at the top
    always_ff @(posedge clk) begin
        if (rst)       value <= LFSR_SEED;
        else if (load) value <= seed;
        else if (en)   value <= {fb, value[15:1]};
    end
endmodule

// File: rtl/pattern_gen_param.sv
// Parametrised frame/line pattern generator.
// Optional feature: define PATGEN_PRBS_EN to enable mode 5 (LFSR pattern);
// without it mode 5 emits 0 like the reserved modes.
module pattern_gen_param
    import pattern_gen_pkg::*;
#(
    parameter int DATA_W      = 12,
    parameter int DELTA_W     = 2,
    parameter int LINE_LEN    = 640,
    parameter int FRAME_LINES = 480,
    parameter int CHK_LOG2    = 3
) (
    input  logic           clk,
    input  logic           rst,
    pattern_gen_param_if.slave bus
);
    localparam int PX_W = pg_w(LINE_LEN);
    localparam int LY_W = pg_w(FRAME_LINES);

    pg_state_e           state, state_nxt;

    // Configuration latched at f_sync so mid-frame input changes are ignored
    logic [2:0]          mode_q;
    logic [DATA_W-1:0]   const_q;
    logic [DELTA_W-1:0]  x_q, y_q;

    // Position of the pixel about to be emitted, plus incremental ramp terms
    logic [DATA_W-1:0]   line_base;
    logic [DATA_W-1:0]   rx;          // pos * X, accumulated
    logic [PX_W-1:0]     pos;
    logic [LY_W-1:0]     row;
    logic                done_pend;   // last pixel of the frame went out last edge

    logic                last_px, last_row, emit, trunc, line_end, chk_odd;
    logic [PX_W-1:0]     pos_cell;
    logic [LY_W-1:0]     row_cell;
    logic [DATA_W-1:0]   pix_val;

`ifdef PATGEN_PRBS_EN
    logic [15:0]         lfsr;
    logic                unused_lfsr_hi;

    pattern_gen_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (emit),
        .load  (bus.f_sync),
        .seed  (LFSR_SEED),
        .value (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state: f_sync restarts from any state; a sync in ACTIVE ends the line early
    always_comb begin
        state_nxt = state;
        if (bus.f_sync) begin
            state_nxt = ST_WAIT_LINE;
        end else begin
            case (state)
                ST_WAIT_LINE: if (bus.sync) state_nxt = ST_ACTIVE;
                ST_ACTIVE: begin
                    if (bus.sync)   state_nxt = last_row ? ST_IDLE : ST_ACTIVE;
                    else if (last_px) state_nxt = last_row ? ST_IDLE : ST_WAIT_LINE;
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Line bookkeeping strobes and the value for the pixel at (pos,row)
    always_comb begin
        last_px  = (pos == PX_W'(LINE_LEN - 1));
        last_row = (row == LY_W'(FRAME_LINES - 1));
        emit     = (state == ST_ACTIVE) && !bus.f_sync && !bus.sync;
        trunc    = (state == ST_ACTIVE) && !bus.f_sync && bus.sync;
        line_end = trunc || (emit && last_px);
        pos_cell = pos >> CHK_LOG2;
        row_cell = row >> CHK_LOG2;
        chk_odd  = pos_cell[0] ^ row_cell[0];
        pix_val  = '0;
        case (mode_q)
            PG_CONST:   pix_val = const_q;
            PG_RAMP_X:  pix_val = const_q + rx;
            PG_RAMP_Y:  pix_val = line_base;
            PG_RAMP_XY: pix_val = line_base + rx;
            PG_CHECKER: pix_val = chk_odd ? ~const_q : const_q;
`ifdef PATGEN_PRBS_EN
            PG_PRBS:    pix_val = lfsr[DATA_W-1:0];
`endif
            default:    pix_val = '0;
        endcase
    end

    // Registered outputs, latched config and position counters
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.cnt        <= '0;
            bus.cnt_vld    <= 1'b0;
            bus.pix_x      <= '0;
            bus.line_y     <= '0;
            bus.frame_done <= 1'b0;
            done_pend      <= 1'b0;
            mode_q         <= '0;
            const_q        <= '0;
            x_q            <= '0;
            y_q            <= '0;
            line_base      <= '0;
            rx             <= '0;
            pos            <= '0;
            row            <= '0;
        end else begin
            bus.cnt_vld    <= emit;
            done_pend      <= emit && last_px && last_row;
            // A truncated final line has no trailing pixel, so it flags at once
            bus.frame_done <= done_pend || (trunc && last_row);
            if (emit) begin
                bus.cnt    <= pix_val;
                bus.pix_x  <= pos;
                bus.line_y <= row;
            end

            if (bus.f_sync) begin
                mode_q     <= bus.Mode;
                const_q    <= bus.constVal;
                x_q        <= bus.X;
                y_q        <= bus.Y;
                line_base  <= bus.constVal;
                rx         <= '0;
                pos        <= '0;
                row        <= '0;
                bus.pix_x  <= '0;
                bus.line_y <= '0;
            end else if (state == ST_WAIT_LINE && bus.sync) begin
                pos <= '0;
                rx  <= '0;
            end else if (line_end) begin
                pos <= '0;
                rx  <= '0;
                row <= last_row ? '0 : row + 1'b1;
                if (mode_q == PG_RAMP_Y || mode_q == PG_RAMP_XY)
                    line_base <= line_base + DATA_W'(y_q);
            end else if (emit) begin
                pos <= pos + 1'b1;
                rx  <= rx + DATA_W'(x_q);
            end
        end
    end
endmodule
